mpram_wport_arb: RTL and testbench
==================================

# mpram_wport_arb

Write-port arbiter and clear sequencer for the LVT multi-ported RAM (`mpram_lvt`). It accepts write requests from `nREQ` requesters over a valid/ready handshake and grants up to `nWPORTS` of them per cycle, round-robin. It never places two writes to the same address in one cycle, because simultaneous same-address writes corrupt the LVT. It also provides a bulk-clear sequence that zeroes every word using all write ports, and drives the RAM's `WEnb`/`WAddr`/`WData` from registers.

## Interface
- `MEMD`, 16: RAM depth in words; `ADDRW = $clog2(MEMD)`.
- `DATAW`, 32: data word width.
- `nREQ`, 4: number of write requesters (≥1).
- `nWPORTS`, 2: number of RAM write ports (≥1, ≤ `nREQ`).
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_valid`, input, `nREQ`: requester i has a write pending.
- `req_addr`, input, `ADDRW*nREQ`: write address of requester i, in slice i.
- `req_data`, input, `DATAW*nREQ`: write data of requester i, in slice i.
- `req_ready`, output, `nREQ`: combinational grant; a write transfers when valid and ready are both high.
- `clr_start`, input, 1: one-cycle request to zero the whole RAM.
- `clr_busy`, output, 1: clear sequence in progress.
- `clr_done`, output, 1: one-cycle pulse when the clear completes.
- `WEnb`, output, `nWPORTS`: registered write enables to the RAM.
- `WAddr`, output, `ADDRW*nWPORTS`: registered write addresses.
- `WData`, output, `DATAW*nWPORTS`: registered write data.

## Operation
- The block has two states, RUN and CLEAR. Reset puts it in RUN with pointer `rr` = 0 and clear counter `ca` = 0.

**RUN grant rule (combinational)**
- Scan requesters in order `rr`, `rr+1`, … modulo `nREQ`.
- Requester j is granted when all of these hold:
  - `req_valid[j]` is high;
  - fewer than `nWPORTS` grants have been made this cycle;
  - `req_addr` of j differs from every address already granted this cycle.
- The k-th grant (k = 0, 1, …) is assigned to write port k.
- A requester that loses on a collision or on port exhaustion keeps `req_ready` = 0 and retries. Holding valid, address and data stable is the requester's responsibility.
- If at least one grant is made, `rr` ← (index of last granted requester + 1) mod `nREQ`. Otherwise `rr` is unchanged.
- When `clr_start` = 1, all `req_ready` are forced to 0 in that same cycle. Next state is CLEAR with `ca` ← 0.

**CLEAR**
- All `req_ready` = 0 and `clr_busy` = 1.
- Each cycle, port p writes 0 to address `ca+p` when `ca+p < MEMD`. Ports whose address would be ≥ `MEMD` are disabled.
- `ca` ← `ca + nWPORTS`.
- When `ca + nWPORTS ≥ MEMD`, the next state is RUN.
- `clr_start` is ignored while in CLEAR.

**Output registers**
- Next `WEnb[p]` = 1 if port p carries a grant or a clear write; the address and data come from that source.
- Unused ports have `WEnb` = 0; their `WAddr`/`WData` hold their previous values.

**Width and wrap rules**
- `rr` is `$clog2(nREQ)` bits, or 1 bit if `nREQ` = 1, and wraps modulo `nREQ`.
- `ca` is `ADDRW+1` bits, so it cannot overflow at `MEMD` equal to a power of two.

## Timing
- Reset values: `WEnb` = 0, `WAddr` = 0, `WData` = 0, `clr_busy` = 0, `clr_done` = 0. `req_ready` = 0 unless a valid request is present in RUN.
- Latency: a handshake in cycle t appears on `WEnb`/`WAddr`/`WData` in cycle t+1. The data is readable through `mpram_lvt` per its RDW setting.
- Clear length: `clr_start` is sampled in cycle t. CLEAR occupies cycles t+1 … t+N, where N = ceil(`MEMD`/`nWPORTS`); `clr_busy` is high in exactly those cycles.
- Clear writes appear on the outputs in cycles t+2 … t+N+1. `clr_done` pulses in cycle t+N+1, coinciding with the last clear write.
- Requests can be granted again from cycle t+N+1. A write granted in cycle t+N+1 lands after all clear writes.
- Asynchronous `rst` at any point, including mid-CLEAR, immediately returns all outputs to reset values, state to RUN, and `rr` and `ca` to 0. A partially completed clear is abandoned and not resumed.

## Test plan
- **Round-robin:** defaults; all 4 requesters valid with addresses 1, 2, 3, 4 held for 2 cycles.
  - Cycle 0 grants req0 on port 0 and req1 on port 1; cycle 1 grants req2 and req3.
  - `WEnb` = 2'b11 in cycles 1 and 2; `rr` returns to 0.
- **Address collision:** req0 and req1 both target address 5 with data A and B, other requesters idle.
  - Only req0 is granted in cycle 0 (`WEnb` = 2'b01 next cycle); req1 is granted in cycle 1.
  - A subsequent read of address 5 returns B.
- **Port exhaustion and fairness:** req3 held valid while req0–req2 are continuously valid with distinct addresses.
  - req3 is granted within 2 cycles; no requester waits more than ceil(`nREQ`/`nWPORTS`) = 2 cycles.
- **Clear:** preload addresses 0–15 with nonzero data, then pulse `clr_start` in cycle t with req0 valid.
  - `req_ready` = 0 in cycles t … t+8; `clr_busy` is high in t+1 … t+8; `clr_done` pulses in t+9.
  - All 16 words read back 0; req0 is granted in t+9.
- **Odd depth:** `MEMD` = 5, `nWPORTS` = 2.
  - Clear writes {0,1}, {2,3}, then {4} with `WEnb` = 2'b01; `clr_busy` is high for 3 cycles.
- **Reset mid-clear:** assert `rst` during the 4th CLEAR cycle.
  - Outputs are 0 immediately and the block is in RUN after release.
  - A new `clr_start` runs the full 8-cycle sequence from address 0.

Source files
------------

// File: rtl/mpram_wport_arb.sv
// Round-robin write-port arbiter and bulk-clear sequencer for the LVT multi-ported RAM.
// Latency: a grant (valid & ready) in cycle t drives WEnb/WAddr/WData in cycle t+1.
// Backpressure: req_ready is combinational; losers on collision/port exhaustion, or any request during clear, see ready=0.
//
// Ports:
//   clk, rst              - clock (rising edge), asynchronous active-high reset
//   req_valid/addr/data   - nREQ write requesters, slice i belongs to requester i
//   req_ready             - per-requester grant for this cycle
//   clr_start             - one-cycle request to zero the whole RAM
//   clr_busy, clr_done    - clear in progress / one-cycle completion pulse
//   WEnb, WAddr, WData    - registered RAM write ports, slice p belongs to port p
module mpram_wport_arb #(
    parameter int MEMD    = 16,
    parameter int DATAW   = 32,
    parameter int nREQ    = 4,
    parameter int nWPORTS = 2,
    localparam int ADDRW  = $clog2(MEMD)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [nREQ-1:0]          req_valid,
    input  logic [ADDRW*nREQ-1:0]    req_addr,
    input  logic [DATAW*nREQ-1:0]    req_data,
    output logic [nREQ-1:0]          req_ready,
    input  logic                     clr_start,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic [nWPORTS-1:0]       WEnb,
    output logic [ADDRW*nWPORTS-1:0] WAddr,
    output logic [DATAW*nWPORTS-1:0] WData
);

    localparam int RRW = (nREQ > 1) ? $clog2(nREQ) : 1;
    // One extra bit so the clear pointer can reach MEMD without wrapping.
    localparam int CAW = ADDRW + 1;

    typedef enum logic {RUN, CLEAR} state_t;

    state_t             state, state_nxt;
    logic [RRW-1:0]     rr, rr_nxt;
    logic [CAW-1:0]     ca, ca_nxt;
    logic               clr_last;

    logic [nWPORTS-1:0] port_vld;
    logic [ADDRW-1:0]   port_addr [nWPORTS];
    logic [DATAW-1:0]   port_dat  [nWPORTS];
    logic               dup;
    int                 ng;
    int                 last_gnt;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        ca_nxt    = ca;
        clr_last  = 1'b0;
        clr_busy  = (state == CLEAR);
        req_ready = '0;
        port_vld  = '0;
        dup       = 1'b0;
        ng        = 0;
        last_gnt  = 0;
        for (int p = 0; p < nWPORTS; p++) begin
            port_addr[p] = '0;
            port_dat[p]  = '0;
        end

        case (state)
            RUN: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                    ca_nxt    = '0;
                end else begin
                    // Scan requesters starting at rr; the k-th winner takes port k.
                    for (int k = 0; k < nREQ; k++) begin
                        for (int j = 0; j < nREQ; j++) begin
                            if (j == (int'(rr) + k) % nREQ && req_valid[j] && ng < nWPORTS) begin
                                // Two same-address writes in one cycle would corrupt the LVT.
                                dup = 1'b0;
                                for (int p = 0; p < nWPORTS; p++) begin
                                    if (p < ng && port_addr[p] == req_addr[j*ADDRW +: ADDRW])
                                        dup = 1'b1;
                                end
                                if (!dup) begin
                                    req_ready[j] = 1'b1;
                                    for (int p = 0; p < nWPORTS; p++) begin
                                        if (p == ng) begin
                                            port_vld[p]  = 1'b1;
                                            port_addr[p] = req_addr[j*ADDRW +: ADDRW];
                                            port_dat[p]  = req_data[j*DATAW +: DATAW];
                                        end
                                    end
                                    ng       = ng + 1;
                                    last_gnt = j;
                                end
                            end
                        end
                    end
                    if (ng > 0)
                        rr_nxt = RRW'((last_gnt + 1) % nREQ);
                end
            end
            CLEAR: begin
                // Port p zeroes ca+p; ports past the end of memory stay idle.
                for (int p = 0; p < nWPORTS; p++) begin
                    if (int'(ca) + p < MEMD) begin
                        port_vld[p]  = 1'b1;
                        port_addr[p] = ADDRW'(int'(ca) + p);
                    end
                end
                ca_nxt = ca + CAW'(nWPORTS);
                if (int'(ca) + nWPORTS >= MEMD) begin
                    state_nxt = RUN;
                    clr_last  = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            rr       <= '0;
            ca       <= '0;
            clr_done <= 1'b0;
            WEnb     <= '0;
            WAddr    <= '0;
            WData    <= '0;
        end else begin
            state    <= state_nxt;
            rr       <= rr_nxt;
            ca       <= ca_nxt;
            clr_done <= clr_last;
            for (int p = 0; p < nWPORTS; p++) begin
                if (port_vld[p]) begin
                    WEnb[p]                  <= 1'b1;
                    WAddr[p*ADDRW +: ADDRW]  <= port_addr[p];
                    WData[p*DATAW +: DATAW]  <= port_dat[p];
                end else begin
                    // Idle ports keep their last address/data to avoid needless toggling.
                    WEnb[p] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mpram_wport_arb.sv
// Bench for mpram_wport_arb: default-parameter instance checked every cycle against a
// queue-based model, plus a MEMD=5 instance checked with literal clear expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from it.
module tb_mpram_wport_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [15:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         clr_start, clr_busy, clr_done;
    logic [1:0]   WEnb;
    logic [7:0]   WAddr;
    logic [63:0]  WData;

    logic [3:0]   req_valid5;
    logic [11:0]  req_addr5;
    logic [127:0] req_data5;
    logic [3:0]   req_ready5;
    logic         clr_start5, clr_busy5, clr_done5;
    logic [1:0]   wenb5;
    logic [5:0]   waddr5;
    logic [63:0]  wdata5;

    int n_chk  = 0;
    int n_pass = 0;

    mpram_wport_arb dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .WEnb(WEnb), .WAddr(WAddr), .WData(WData)
    );

    mpram_wport_arb #(.MEMD(5)) dut5 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid5), .req_addr(req_addr5), .req_data(req_data5), .req_ready(req_ready5),
        .clr_start(clr_start5), .clr_busy(clr_busy5), .clr_done(clr_done5),
        .WEnb(wenb5), .WAddr(waddr5), .WData(wdata5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (default parameters) ----------------
    bit          m_clear;
    int          m_rr;
    int          clr_q[$];
    logic [3:0]  gq[$];
    logic [1:0]  e_wenb, n_wenb;
    logic [7:0]  e_waddr, n_waddr;
    logic [63:0] e_wdata, n_wdata;
    bit          e_done, n_done, n_clear;
    int          n_rr;
    logic [3:0]  exp_ready;
    logic [3:0]  m_a;
    int          m_j;
    bit          m_dup;
    logic [31:0] mem [16];

    initial begin
        m_clear = 0; m_rr = 0; e_wenb = 0; e_waddr = 0; e_wdata = 0; e_done = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            m_clear = 0; m_rr = 0; clr_q.delete();
            e_wenb = 0; e_waddr = 0; e_wdata = 0; e_done = 0;
        end
        exp_ready = 0; n_wenb = 0; n_waddr = e_waddr; n_wdata = e_wdata;
        n_done = 0; n_clear = m_clear; n_rr = m_rr;
        if (!m_clear) begin
            if (clr_start) begin
                n_clear = 1;
                clr_q.delete();
                for (int a = 0; a < 16; a++) clr_q.push_back(a);
            end else begin
                gq.delete();
                for (int k = 0; k < 4; k++) begin
                    m_j = (m_rr + k) % 4;
                    m_a = req_addr[m_j*4 +: 4];
                    if (req_valid[m_j] && gq.size() < 2) begin
                        m_dup = 0;
                        foreach (gq[i]) if (gq[i] == m_a) m_dup = 1;
                        if (!m_dup) begin
                            n_wenb[gq.size()] = 1'b1;
                            n_waddr[gq.size()*4 +: 4] = m_a;
                            n_wdata[gq.size()*32 +: 32] = req_data[m_j*32 +: 32];
                            gq.push_back(m_a);
                            exp_ready[m_j] = 1'b1;
                            n_rr = (m_j + 1) % 4;
                        end
                    end
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (clr_q.size() > 0) begin
                    n_wenb[p] = 1'b1;
                    n_waddr[p*4 +: 4] = 4'(clr_q.pop_front());
                    n_wdata[p*32 +: 32] = 32'h0;
                end
            end
            if (clr_q.size() == 0) begin
                n_clear = 0;
                n_done = 1;
            end
        end

        chk("mdl_req_ready", req_ready, exp_ready);
        chk("mdl_wenb", WEnb, e_wenb);
        chk("mdl_waddr", WAddr, e_waddr);
        chk("mdl_wdata", WData, e_wdata);
        chk("mdl_clr_busy", clr_busy, m_clear);
        chk("mdl_clr_done", clr_done, e_done);

        for (int p = 0; p < 2; p++)
            if (WEnb[p] === 1'b1) mem[WAddr[p*4 +: 4]] = WData[p*32 +: 32];

        if (!rst) begin
            m_clear = n_clear; m_rr = n_rr;
            e_wenb = n_wenb; e_waddr = n_waddr; e_wdata = n_wdata; e_done = n_done;
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus with literal expectations ----------------
    int wt [4];

    initial begin
        rst = 1'b1; req_valid = 0; req_addr = 0; req_data = 0; clr_start = 0;
        req_valid5 = 0; req_addr5 = 0; req_data5 = 0; clr_start5 = 0;
        #3;
        chk("rst_wenb", WEnb, 2'b00);
        chk("rst_waddr", WAddr, 8'h00);
        chk("rst_wdata", WData, 64'h0);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        chk("rst_ready", req_ready, 4'b0000);
        cyc(); cyc();
        rst = 1'b0;

        // Round-robin: four requesters, addresses 1..4.
        req_addr = 16'h4321;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0A0_0000 + i;
        req_valid = 4'b1111;
        #3 chk("rr_c0_ready", req_ready, 4'b0011);
        cyc();
        #3;
        chk("rr_c1_ready", req_ready, 4'b1100);
        chk("rr_c1_wenb", WEnb, 2'b11);
        chk("rr_c1_waddr", WAddr, 8'h21);
        chk("rr_c1_wdata", WData, {32'hA0A0_0001, 32'hA0A0_0000});
        cyc();
        req_valid = 0;
        #3;
        chk("rr_c2_wenb", WEnb, 2'b11);
        chk("rr_c2_waddr", WAddr, 8'h43);
        chk("rr_c2_wdata", WData, {32'hA0A0_0003, 32'hA0A0_0002});
        cyc();
        req_valid = 4'b1111;
        #3 chk("rr_wrap_ready", req_ready, 4'b0011);
        cyc();
        req_valid = 0;
        cyc();

        // Address collision: req0 and req1 both write address 5.
        req_addr[3:0] = 4'd5; req_data[31:0]  = 32'h0000_AAAA;
        req_addr[7:4] = 4'd5; req_data[63:32] = 32'h0000_BBBB;
        req_valid = 4'b0011;
        #3 chk("col_c0_ready", req_ready, 4'b0001);
        cyc();
        req_valid = 4'b0010;
        #3;
        chk("col_c1_ready", req_ready, 4'b0010);
        chk("col_c1_wenb", WEnb, 2'b01);
        chk("col_c1_addr", WAddr[3:0], 4'd5);
        chk("col_c1_data", WData[31:0], 32'h0000_AAAA);
        cyc();
        req_valid = 0;
        #3;
        chk("col_c2_wenb", WEnb, 2'b01);
        chk("col_c2_data", WData[31:0], 32'h0000_BBBB);
        cyc();
        #3 chk("col_mem5", mem[5], 32'h0000_BBBB);

        // Port exhaustion and fairness: all four continuously valid.
        req_addr = 16'h9876;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) wt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (c == 0) chk("fair_c0_ready", req_ready, 4'b1100);
            for (int j = 0; j < 4; j++) begin
                if (req_ready[j]) wt[j] = 0;
                else wt[j]++;
                chk("fair_wait_le1", (wt[j] <= 1), 1'b1);
            end
            cyc();
        end
        req_valid = 0;
        cyc();

        // Preload all 16 words with nonzero data.
        for (int k = 0; k < 8; k++) begin
            req_addr[3:0] = 4'(2*k);     req_data[31:0]  = 32'h100 + 2*k;
            req_addr[7:4] = 4'(2*k + 1); req_data[63:32] = 32'h100 + 2*k + 1;
            req_valid = 4'b0011;
            cyc();
        end
        req_valid = 0;
        cyc(); cyc();
        #3;
        for (int i = 0; i < 16; i++) chk("pre_mem", mem[i], 32'h100 + i);
        cyc();

        // Clear with req0 waiting.
        req_addr[3:0] = 4'd3; req_data[31:0] = 32'h1234;
        req_valid = 4'b0001;
        clr_start = 1'b1;
        #3;
        chk("clr_t_ready", req_ready, 4'b0000);
        chk("clr_t_busy", clr_busy, 1'b0);
        cyc();
        clr_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #3;
            chk("clr_ready0", req_ready, 4'b0000);
            chk("clr_busy1", clr_busy, 1'b1);
            chk("clr_done0", clr_done, 1'b0);
            if (i == 2) begin
                chk("clr_first_wenb", WEnb, 2'b11);
                chk("clr_first_waddr", WAddr, 8'h10);
            end
            cyc();
        end
        #3;
        chk("clr_t9_ready", req_ready, 4'b0001);
        chk("clr_t9_busy", clr_busy, 1'b0);
        chk("clr_t9_done", clr_done, 1'b1);
        chk("clr_t9_wenb", WEnb, 2'b11);
        chk("clr_t9_waddr", WAddr, 8'hFE);
        cyc();
        req_valid = 0;
        #3;
        for (int i = 0; i < 16; i++) chk("clr_mem_zero", mem[i], 32'h0);
        chk("clr_t10_wenb", WEnb, 2'b01);
        chk("clr_t10_waddr", WAddr, 8'hF3);
        chk("clr_t10_wdata", WData[31:0], 32'h1234);
        cyc();

        // Odd depth: MEMD = 5.
        clr_start5 = 1'b1;
        #3 chk("odd_t_busy", clr_busy5, 1'b0);
        cyc();
        clr_start5 = 1'b0;
        #3;
        chk("odd_t1_busy", clr_busy5, 1'b1);
        chk("odd_t1_wenb", wenb5, 2'b00);
        cyc();
        #3;
        chk("odd_t2_busy", clr_busy5, 1'b1);
        chk("odd_t2_wenb", wenb5, 2'b11);
        chk("odd_t2_waddr", waddr5, 6'b001_000);
        cyc();
        #3;
        chk("odd_t3_busy", clr_busy5, 1'b1);
        chk("odd_t3_wenb", wenb5, 2'b11);
        chk("odd_t3_waddr", waddr5, 6'b011_010);
        chk("odd_t3_done", clr_done5, 1'b0);
        cyc();
        #3;
        chk("odd_t4_busy", clr_busy5, 1'b0);
        chk("odd_t4_done", clr_done5, 1'b1);
        chk("odd_t4_wenb", wenb5, 2'b01);
        chk("odd_t4_waddr", waddr5, 6'b011_100);
        chk("odd_t4_wdata", wdata5, 64'h0);
        cyc();
        #3;
        chk("odd_t5_done", clr_done5, 1'b0);
        chk("odd_t5_wenb", wenb5, 2'b00);
        cyc();

        // Reset during the 4th clear cycle.
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        cyc(); cyc(); cyc();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wenb", WEnb, 2'b00);
        chk("mid_rst_waddr", WAddr, 8'h00);
        chk("mid_rst_wdata", WData, 64'h0);
        chk("mid_rst_busy", clr_busy, 1'b0);
        chk("mid_rst_done", clr_done, 1'b0);
        cyc();
        rst = 1'b0;
        #3 chk("post_rst_busy", clr_busy, 1'b0);
        cyc();
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #3;
            chk("reclr_busy1", clr_busy, 1'b1);
            if (i == 2) chk("reclr_first_waddr", WAddr, 8'h10);
            cyc();
        end
        #3;
        chk("reclr_done", clr_done, 1'b1);
        chk("reclr_busy0", clr_busy, 1'b0);
        chk("reclr_last_waddr", WAddr, 8'hFE);
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
